// File: rtl/alu_pkg.sv
// alu_pkg: ALU op encoding, flag bit indices and operand decode helpers
package alu_pkg;
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_ADC = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_SBC = 2'b11;
  localparam int FLAG_C = 0;
  localparam int FLAG_V = 1;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 3;

  function automatic logic inv_b(input logic [1:0] op);
    return (op == OP_SUB) || (op == OP_SBC);
  endfunction

  function automatic logic eff_cin(input logic [1:0] op, input logic cin);
    return (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;
  endfunction
endpackage

// File: rtl/cla_slice.sv
// cla_slice: combinational N-bit two-level carry-lookahead adder slice
module cla_slice #(
  parameter int N = 16,
  parameter int GROUP = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         c_msb,
  output logic         zero
);
  localparam int NG = N / GROUP;
  logic [N-1:0] g, p;
  logic [NG-1:0] gg, gp;
  logic [N:0] c;
  assign g = a & b;
  assign p = a ^ b;
  always_comb begin
    gg = '0;
    gp = '0;
    c = '0;
    for (int i = 0; i < NG; i++) begin
      gp[i] = &p[i*GROUP +: GROUP];
      for (int j = 0; j < GROUP; j++) gg[i] = g[i*GROUP+j] | (p[i*GROUP+j] & gg[i]);
    end
    c[0] = cin;
    for (int i = 0; i < NG; i++) begin
      c[(i+1)*GROUP] = gg[i] | (gp[i] & c[i*GROUP]);
      for (int j = 1; j < GROUP; j++) c[i*GROUP+j] = g[i*GROUP+j-1] | (p[i*GROUP+j-1] & c[i*GROUP+j-1]);
    end
  end
  assign sum = p ^ c[N-1:0];
  assign cout = c[N];
  assign c_msb = c[N-1];
  assign zero = ~|sum;
endmodule

// File: rtl/cla_addsub_pipe.sv
// cla_addsub_pipe: pipelined carry-lookahead add/sub with valid/ready handshake,
// C/V/Z/N flags and a pass-through tag; one slice of the add per stage.
module cla_addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int GROUP = 4,
  parameter int STAGES = 2,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  input  logic             in_cin,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_c,
  output logic             out_v,
  output logic             out_z,
  output logic             out_n,
  output logic [TAG_W-1:0] out_tag
);
  localparam int SW = WIDTH / STAGES;
  logic adv;
  logic [WIDTH-1:0] x_in [STAGES];
  logic [WIDTH-1:0] y_in [STAGES];
  logic [WIDTH-1:0] x_r [STAGES];
  logic [WIDTH-1:0] y_r [STAGES];
  logic [SW-1:0] s_sum [STAGES];
  logic [TAG_W-1:0] t_in [STAGES];
  logic [TAG_W-1:0] t_r [STAGES];
  logic cm [STAGES];
  logic [STAGES-1:0] c_in, z_in, vl_in, co, zs, c_r, z_r, vl_r;
  logic v_r;
  assign adv = !out_valid || out_ready;
  assign in_ready = adv;
  // x carries finished sums in its low slices and untouched A bits above them
  always_comb begin
    x_in[0] = in_a;
    y_in[0] = inv_b(in_op) ? ~in_b : in_b;
    t_in[0] = in_tag;
    c_in[0] = eff_cin(in_op, in_cin);
    z_in[0] = 1'b1;
    vl_in[0] = in_valid;
    for (int i = 1; i < STAGES; i++) begin
      x_in[i] = x_r[i-1];
      y_in[i] = y_r[i-1];
      t_in[i] = t_r[i-1];
      c_in[i] = c_r[i-1];
      z_in[i] = z_r[i-1];
      vl_in[i] = vl_r[i-1];
    end
  end
  for (genvar s = 0; s < STAGES; s++) begin : g_st
    cla_slice #(.N(SW), .GROUP(GROUP)) u_slice (
      .a(x_in[s][s*SW +: SW]),
      .b(y_in[s][s*SW +: SW]),
      .cin(c_in[s]),
      .sum(s_sum[s]),
      .cout(co[s]),
      .c_msb(cm[s]),
      .zero(zs[s])
    );
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) begin
        x_r[i] <= '0;
        y_r[i] <= '0;
        t_r[i] <= '0;
      end
      c_r <= '0;
      z_r <= '0;
      vl_r <= '0;
      v_r <= 1'b0;
    end else if (adv) begin
      for (int i = 0; i < STAGES; i++) begin
        x_r[i] <= x_in[i];
        x_r[i][i*SW +: SW] <= s_sum[i];
        y_r[i] <= y_in[i];
        t_r[i] <= t_in[i];
      end
      c_r <= co;
      z_r <= z_in & zs;
      vl_r <= vl_in;
      v_r <= cm[STAGES-1] ^ co[STAGES-1];
    end
  assign out_valid = vl_r[STAGES-1];
  assign out_sum = x_r[STAGES-1];
  assign out_c = c_r[STAGES-1];
  assign out_v = v_r;
  assign out_z = z_r[STAGES-1];
  assign out_n = x_r[STAGES-1][WIDTH-1];
  assign out_tag = t_r[STAGES-1];
endmodule

// File: tb/tb_cla_addsub_pipe.sv
// tb_cla_addsub_pipe: directed and randomized checks of three pipeline configurations
module tb_cla_addsub_pipe;
  logic clk = 0, rst_n = 0;
  logic [2:0] iv = '0, ordy = '1;
  logic [2:0] ir, ov, oc, ovf, oz, on;
  logic [63:0] a = '0, b = '0;
  logic [1:0] op = '0;
  logic cin = 0;
  logic [4:0] tag = '0;
  logic [31:0] s0, s1;
  logic [63:0] s2;
  logic [4:0] t0, t1, t2;
  int checks = 0, passed = 0;

  always #5 clk = ~clk;

  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(1), .TAG_W(5)) d0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_a(a[31:0]), .in_b(b[31:0]),
    .in_op(op), .in_cin(cin), .in_tag(tag), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(s0),
    .out_c(oc[0]), .out_v(ovf[0]), .out_z(oz[0]), .out_n(on[0]), .out_tag(t0));
  cla_addsub_pipe #(.WIDTH(32), .GROUP(4), .STAGES(2), .TAG_W(5)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_a(a[31:0]), .in_b(b[31:0]),
    .in_op(op), .in_cin(cin), .in_tag(tag), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(s1),
    .out_c(oc[1]), .out_v(ovf[1]), .out_z(oz[1]), .out_n(on[1]), .out_tag(t1));
  cla_addsub_pipe #(.WIDTH(64), .GROUP(4), .STAGES(4), .TAG_W(5)) d2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_a(a), .in_b(b),
    .in_op(op), .in_cin(cin), .in_tag(tag), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(s2),
    .out_c(oc[2]), .out_v(ovf[2]), .out_z(oz[2]), .out_n(on[2]), .out_tag(t2));

  // result packing: {tag, n, z, v, c, sum}
  function automatic logic [72:0] got(input int k);
    case (k)
      0: return {t0, on[0], oz[0], ovf[0], oc[0], 32'h0, s0};
      1: return {t1, on[1], oz[1], ovf[1], oc[1], 32'h0, s1};
      default: return {t2, on[2], oz[2], ovf[2], oc[2], s2};
    endcase
  endfunction

  function automatic logic [72:0] model(input int w, input logic [1:0] o, input logic [63:0] ai, bi,
                                        input logic ci, input logic [4:0] tg);
    logic [64:0] t;
    logic [63:0] m, x, y, s;
    logic c, v;
    m = (w == 64) ? '1 : 64'h0000_0000_FFFF_FFFF;
    x = ai & m;
    y = bi & m;
    case (o)
      2'b00: t = {1'b0, x} + {1'b0, y};
      2'b01: t = {1'b0, x} + {1'b0, y} + 65'(ci);
      2'b10: begin
        t[63:0] = x - y;
        t[64] = 1'b0;
      end
      default: t = {1'b0, x} + {1'b0, ~y & m} + 65'(ci);
    endcase
    s = t[63:0] & m;
    if (o == 2'b10) c = (x >= y);
    else c = t[w];
    if (o[1]) y = ~y & m;
    v = (x[w-1] == y[w-1]) && (s[w-1] != x[w-1]);
    return {tg, s[w-1], s == 0, v, c, s};
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(5))
      0: return '0;
      1: return '1;
      2: return 64'h8000_0000_8000_0000;
      3: return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic run_one(input int k, input logic [1:0] o, input logic [63:0] ai, bi,
                         input logic ci, input logic [4:0] tg, output int lat, output logic [72:0] r);
    @(negedge clk);
    ordy = '1;
    iv = '0;
    iv[k] = 1'b1;
    op = o; a = ai; b = bi; cin = ci; tag = tg;
    @(negedge clk);
    iv = '0;
    lat = 1;
    while (!ov[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    r = got(k);
  endtask

  task automatic test_reset;
    #1;
    checks++; if (ov !== 3'b000) $display("FAIL reset_valid got %b want 000", ov); else passed++;
    checks++; if (ir !== 3'b111) $display("FAIL reset_ready got %b want 111", ir); else passed++;
    for (int k = 0; k < 3; k++) begin
      checks++; if (got(k) !== '0) $display("FAIL reset_out%0d got %h want 0", k, got(k)); else passed++;
    end
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++; if (ov !== 3'b000) $display("FAIL post_reset_valid got %b want 000", ov); else passed++;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    ordy = '1;
    iv[1] = 1; op = 2'b00; a = 5; b = 6; tag = 1;
    @(negedge clk);
    a = 7; tag = 2;
    @(negedge clk);
    iv[1] = 0;
    #2 rst_n = 0;
    #1;
    checks++; if (ov !== 3'b000) $display("FAIL midreset_valid got %b want 000", ov); else passed++;
    checks++; if (ir !== 3'b111) $display("FAIL midreset_ready got %b want 111", ir); else passed++;
    checks++; if (got(1) !== '0) $display("FAIL midreset_out got %h want 0", got(1)); else passed++;
    @(negedge clk);
    rst_n = 1;
    repeat (3) @(negedge clk);
    checks++; if (ov !== 3'b000) $display("FAIL midreset_flush got %b want 000", ov); else passed++;
  endtask

  task automatic test_add_wrap;
    int lat;
    logic [72:0] r;
    run_one(1, 2'b00, 64'hFFFF_FFFF, 64'h1, 1'b1, 5'd3, lat, r);
    checks++; if (lat != 2) $display("FAIL add_wrap_latency got %0d want 2", lat); else passed++;
    checks++; if (r !== {5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0})
      $display("FAIL add_wrap got %h want %h", r, {5'd3, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0}); else passed++;
    run_one(0, 2'b00, 64'hFFFF_FFFF, 64'h1, 1'b0, 5'd4, lat, r);
    checks++; if (lat != 1) $display("FAIL add_wrap_s1_latency got %0d want 1", lat); else passed++;
    checks++; if (r !== {5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0})
      $display("FAIL add_wrap_s1 got %h want %h", r, {5'd4, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0}); else passed++;
  endtask

  task automatic test_sub_adc;
    int lat;
    logic [72:0] r;
    run_one(1, 2'b10, 64'h8000_0000, 64'h1, 1'b0, 5'd7, lat, r);
    checks++; if (r !== {5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 64'h7FFF_FFFF})
      $display("FAIL sub_ovf got %h want %h", r, {5'd7, 1'b0, 1'b0, 1'b1, 1'b1, 64'h7FFF_FFFF}); else passed++;
    run_one(1, 2'b01, 64'd5, 64'd7, 1'b1, 5'd9, lat, r);
    checks++; if (r !== {5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 64'd13})
      $display("FAIL adc got %h want %h", r, {5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 64'd13}); else passed++;
    run_one(1, 2'b11, 64'd5, 64'd5, 1'b0, 5'd10, lat, r);
    checks++; if (r !== {5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF})
      $display("FAIL sbc_borrow got %h want %h", r, {5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF}); else passed++;
  endtask

  task automatic test_cross_slice;
    int lat;
    logic [72:0] r;
    run_one(1, 2'b00, 64'h0000_FFFF, 64'h1, 1'b0, 5'd11, lat, r);
    checks++; if (r !== {5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0001_0000})
      $display("FAIL cross_slice got %h want %h", r, {5'd11, 1'b0, 1'b0, 1'b0, 1'b0, 64'h0001_0000}); else passed++;
    run_one(2, 2'b00, '1, 64'h1, 1'b0, 5'd12, lat, r);
    checks++; if (lat != 4) $display("FAIL cross64_latency got %0d want 4", lat); else passed++;
    checks++; if (r !== {5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0})
      $display("FAIL cross64 got %h want %h", r, {5'd12, 1'b0, 1'b1, 1'b0, 1'b1, 64'h0}); else passed++;
  endtask

  task automatic test_stall;
    logic [72:0] q[$];
    logic [72:0] prev, e;
    int sent = 0, rcv = 0;
    logic pend = 0, was_stalled = 0;
    prev = '0;
    for (int cyc = 0; cyc < 40 && rcv < 8; cyc++) begin
      @(negedge clk);
      ordy[1] = !(cyc >= 3 && cyc <= 6);
      if (!pend && sent < 8) begin
        a = {32'h0, $urandom}; b = {32'h0, $urandom}; op = 2'($urandom_range(3));
        cin = 1'($urandom_range(1)); tag = 5'(sent);
      end
      iv[1] = (sent < 8);
      #1;
      if (was_stalled) begin
        checks++; if (got(1) !== prev) $display("FAIL stall_hold got %h want %h", got(1), prev); else passed++;
      end
      if (!ordy[1] && ov[1]) begin
        checks++; if (ir[1] !== 1'b0) $display("FAIL stall_ready got %b want 0", ir[1]); else passed++;
      end
      if (iv[1] && ir[1]) begin
        q.push_back(model(32, op, a, b, cin, tag));
        sent++;
      end
      pend = iv[1] && !ir[1];
      if (ov[1] && ordy[1]) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++; if (got(1) !== e) $display("FAIL stall_order got %h want %h", got(1), e); else passed++;
        rcv++;
      end
      was_stalled = ov[1] && !ordy[1];
      prev = got(1);
    end
    iv[1] = 0;
    ordy[1] = 1;
    checks++; if (rcv != 8) $display("FAIL stall_count got %0d want 8", rcv); else passed++;
  endtask

  task automatic test_random(input int k, input int w, input int n);
    logic [72:0] q[$];
    logic [72:0] e;
    int sent = 0, rcv = 0;
    logic pend = 0;
    for (int cyc = 0; cyc < 3 * n && rcv < n; cyc++) begin
      @(negedge clk);
      ordy[k] = ($urandom_range(7) != 0);
      if (!pend) begin
        a = pick(); b = pick(); op = 2'($urandom_range(3));
        cin = 1'($urandom_range(1)); tag = 5'($urandom_range(31));
      end
      iv[k] = pend || (sent < n && $urandom_range(7) != 0);
      #1;
      if (iv[k] && ir[k]) begin
        q.push_back(model(w, op, a, b, cin, tag));
        sent++;
      end
      pend = iv[k] && !ir[k];
      if (ov[k] && ordy[k]) begin
        e = (q.size() > 0) ? q.pop_front() : 'x;
        checks++; if (got(k) !== e) $display("FAIL random%0d got %h want %h", k, got(k), e); else passed++;
        rcv++;
      end
    end
    iv[k] = 0;
    ordy[k] = 1;
    checks++; if (rcv != n) $display("FAIL random%0d_count got %0d want %0d", k, rcv, n); else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_add_wrap();
    test_sub_adc();
    test_cross_slice();
    test_stall();
    test_reset_mid();
    test_random(0, 32, 10000);
    test_random(1, 32, 10000);
    test_random(2, 64, 10000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
